// File: rtl/final_mem_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : final_mem_stream_loader
//  Purpose  : Packs an Avalon-ST byte stream into little-endian 32-bit words
//             and writes them to consecutive (wrapping) on-chip memory words.
//  Options  : FINAL_MEM_LOADER_VERIFY_EN - read back each written word and
//             raise a sticky error flag on mismatch.
//  Revision : 1.0 - initial release
// ============================================================================
module final_mem_stream_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        st_data,
    input  logic              st_valid,
    output logic              st_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Largest loadable count: the whole memory.
    localparam logic [ADDR_W:0] c_max_words = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_one       = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        VRD     = 3'd3,
        VCMP    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_index;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_clken;

    logic [ADDR_W:0]   w_eff_count;
    logic [ADDR_W:0]   w_next_index;
    logic              w_last;
    logic              w_accept;
    logic              w_start_ok;

    assign w_eff_count  = (word_count > c_max_words) ? c_max_words : word_count;
    assign w_next_index = r_index + c_one;
    assign w_last       = (w_next_index == r_count);
    assign w_accept     = (r_state == COLLECT) && st_valid;
    assign w_start_ok   = (r_state == IDLE) && start;

    assign m_address    = r_addr;
    assign m_writedata  = r_wdata;
    assign m_clken      = r_clken;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and memory/stream strobes.
    always_comb begin
        w_state_next = r_state;
        st_ready     = 1'b0;
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_byteenable = 4'h0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (w_eff_count != '0) ? COLLECT : DONE;
                end
            end
            COLLECT: begin
                st_ready = 1'b1;
                if (st_valid && (r_byte_cnt == 2'd3)) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_byteenable = 4'hF;
`ifdef FINAL_MEM_LOADER_VERIFY_EN
                w_state_next = VRD;
`else
                w_state_next = w_last ? DONE : COLLECT;
`endif
            end
`ifdef FINAL_MEM_LOADER_VERIFY_EN
            VRD: begin
                m_chipselect = 1'b1;
                m_byteenable = 4'hF;
                w_state_next = VCMP;
            end
            VCMP: begin
                w_state_next = w_last ? DONE : COLLECT;
            end
`endif
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Load bookkeeping, byte packing and the held address/data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clken    <= 1'b0;
            r_base     <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_byte_cnt <= 2'd0;
            r_word     <= 24'h0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
        end else begin
            r_clken <= 1'b1;
            if (w_start_ok) begin
                r_base     <= start_addr;
                r_count    <= w_eff_count;
                r_index    <= '0;
                r_byte_cnt <= 2'd0;
            end
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0: r_word[7:0]   <= st_data;
                    2'd1: r_word[15:8]  <= st_data;
                    2'd2: r_word[23:16] <= st_data;
                    default: begin
                        // Last byte: latch the full word and its target
                        // address so they are stable during WRITE.
                        r_wdata <= {st_data, r_word};
                        r_addr  <= r_base + r_index[ADDR_W-1:0];
                    end
                endcase
            end
`ifdef FINAL_MEM_LOADER_VERIFY_EN
            if (r_state == VCMP) begin
                r_index <= w_next_index;
            end
`else
            if (r_state == WRITE) begin
                r_index <= w_next_index;
            end
`endif
        end
    end

`ifdef FINAL_MEM_LOADER_VERIFY_EN
    logic r_error;

    assign error = r_error;

    // Sticky readback mismatch flag, cleared by each accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (w_start_ok) begin
            r_error <= 1'b0;
        end else if ((r_state == VCMP) && (m_readdata != r_wdata)) begin
            r_error <= 1'b1;
        end
    end
`else
    logic w_unused_readdata;

    assign w_unused_readdata = ^m_readdata;
    assign error             = 1'b0;
`endif

endmodule
`default_nettype wire
